// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment receive path: active-low digit patterns,
// the blank pattern and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low a..g patterns for hex digits 0..F, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } cap_state_e;

  // Digit position of the single low anode bit; callers guarantee exactly one is low.
  function automatic logic [1:0] anode_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-7-segment encoder: active-low pattern in,
// {valid, blank, nibble} out. Blank is not a valid hex digit.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no latch is inferred.
    valid  = 1'b0;
    nibble = 4'h0;
    blank  = (seg == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == HEX_SEG[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Monitors a multiplexed active-low 7-segment bus, latches each settled digit and
// rebuilds the displayed 8-bit value from complete, well-formed frames.
module seven_seg_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [6:0] seg_in,
  output logic [7:0] num_out,
  output logic       num_valid,
  output logic       frame_stb,
  output logic       decode_err,
  output logic       display_on
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]    an_q, an_p;
  logic [6:0]    seg_q, seg_p;
  cap_state_e    state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_cnt_q;
  logic [3:0]    seen_q, seen_d;
  logic [3:0]    nib_q [4];
  logic [3:0]    blank_q;
  logic          bad_q, bad_d, frame_pend_q, frame_pend_d;

  logic       same, one_low, multi_low, start, advance, latch, timed_out, frame_good;
  logic [1:0] k;
  logic       pat_valid, pat_blank;
  logic [3:0] pat_nib;

  seg7_to_hex u_dec (
    .seg   (seg_q),
    .valid (pat_valid),
    .blank (pat_blank),
    .nibble(pat_nib)
  );

  always_comb begin
    same      = (an_q == an_p) && (seg_q == seg_p);
    one_low   = ($countones(~an_q) == 1);
    multi_low = ($countones(~an_q) > 1);
    k         = anode_index(an_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    advance = 1'b0;
    latch   = 1'b0;
    if (multi_low) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   start = one_low;
        ST_SETTLE: begin
          if (same)         advance = 1'b1;
          else if (one_low) start   = 1'b1;
          else              state_d = ST_IDLE;
        end
        ST_HELD: begin
          // A dwell latches once; only a change of sample can start a new one.
          if (!same) begin
            if (one_low) start   = 1'b1;
            else         state_d = ST_IDLE;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
    if (start)        cnt_d = SW'(1);
    else if (advance) cnt_d = cnt_q + SW'(1);
    if (start || advance) begin
      if (cnt_d == SW'(SETTLE_CYCLES)) begin
        latch   = 1'b1;
        state_d = ST_HELD;
      end else begin
        state_d = ST_SETTLE;
      end
    end
  end

  always_comb begin
    timed_out    = (to_cnt_q == TW'(TIMEOUT_CYCLES)) && !latch;
    seen_d       = (frame_pend_q ? 4'b0000 : seen_q) | (latch ? (4'b0001 << k) : 4'b0000);
    if (timed_out) seen_d = 4'b0000;
    bad_d        = (frame_pend_q ? 1'b0 : bad_q) | (latch && !pat_valid && !pat_blank);
    frame_pend_d = latch && (seen_d == 4'b1111);
    frame_good   = !bad_q && !blank_q[0] && !blank_q[1] && blank_q[2] && blank_q[3];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Input registers reset to the idle bus so no phantom sample follows reset.
      an_q         <= 4'b1111;
      an_p         <= 4'b1111;
      seg_q        <= SEG_BLANK;
      seg_p        <= SEG_BLANK;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      seen_q       <= '0;
      blank_q      <= '0;
      bad_q        <= 1'b0;
      frame_pend_q <= 1'b0;
      num_out      <= '0;
      num_valid    <= 1'b0;
      frame_stb    <= 1'b0;
      decode_err   <= 1'b0;
      display_on   <= 1'b0;
      for (int i = 0; i < 4; i++) nib_q[i] <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so every read sees pre-edge values.
      an_q         <= an;
      seg_q        <= seg_in;
      an_p         <= an_q;
      seg_p        <= seg_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      bad_q        <= bad_d;
      frame_pend_q <= frame_pend_d;
      frame_stb    <= 1'b0;
      decode_err   <= multi_low || (latch && !pat_valid && !pat_blank) ||
                      (frame_pend_q && !frame_good && !bad_q);

      if (latch) begin
        nib_q[k]   <= pat_nib;
        blank_q[k] <= pat_blank;
        to_cnt_q   <= '0;
        display_on <= 1'b1;
      end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      if (timed_out) begin
        display_on <= 1'b0;
        num_valid  <= 1'b0;
      end else if (frame_pend_q && frame_good) begin
        num_out   <= {nib_q[1], nib_q[0]};
        num_valid <= 1'b1;
        frame_stb <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: directed bus frames push expected values,
// a negedge monitor pops them on every frame strobe.
module tb_seven_seg_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;
  localparam logic [6:0] BLK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an = 4'b1111;
  logic [6:0] seg_in = BLK;
  logic [7:0] num_out;
  logic       num_valid, frame_stb, decode_err, display_on;

  int tests = 0;
  int fails = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  seven_seg_capture #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .an        (an),
    .seg_in    (seg_in),
    .num_out   (num_out),
    .num_valid (num_valid),
    .frame_stb (frame_stb),
    .decode_err(decode_err),
    .display_on(display_on)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an     = a;
    seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b1111, BLK, n);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    drive(4'b1110, s0, 8);
    drive(4'b1101, s1, 8);
    drive(4'b1011, s2, 8);
    drive(4'b0111, s3, 8);
  endtask

  // Monitor: every strobe must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (decode_err) err_cnt++;
      if (frame_stb) begin
        stb_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got num_out 0x%0h, expected no strobe", num_out);
        end else begin
          check("frame_num", 32'(num_out), 32'(exp_q.pop_front()));
          check("frame_valid", 32'(num_valid), 32'd1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_num_out", 32'(num_out), 32'h0);
    check("rst_num_valid", 32'(num_valid), 32'd0);
    check("rst_frame_stb", 32'(frame_stb), 32'd0);
    check("rst_decode_err", 32'(decode_err), 32'd0);
    check("rst_display_on", 32'(display_on), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // 1: clean frame "21"
    exp_q.push_back(8'h21);
    frame(7'h79, 7'h24, BLK, BLK);
    idle(4);
    check("t1_stb_cnt", 32'(stb_cnt), 32'd1);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);
    check("t1_num_out", 32'(num_out), 32'h21);
    check("t1_num_valid", 32'(num_valid), 32'd1);
    check("t1_display_on", 32'(display_on), 32'd1);

    // 2: short dwell on digit 0 ("5") must not latch; later "4" completes frame "34"
    drive(4'b1110, 7'h12, SETTLE - 1);
    drive(4'b1101, 7'h30, 8);
    drive(4'b1011, BLK, 8);
    drive(4'b0111, BLK, 8);
    idle(4);
    check("t2_no_frame", 32'(stb_cnt), 32'd1);
    exp_q.push_back(8'h34);
    drive(4'b1110, 7'h19, 8);
    idle(4);
    check("t2_stb_cnt", 32'(stb_cnt), 32'd2);
    check("t2_err_cnt", 32'(err_cnt), 32'd0);

    // 3: one multi-anode sample mid-frame
    exp_q.push_back(8'h21);
    drive(4'b1110, 7'h79, 8);
    drive(4'b1100, 7'h79, 1);
    drive(4'b1101, 7'h24, 8);
    drive(4'b1011, BLK, 8);
    drive(4'b0111, BLK, 8);
    idle(4);
    check("t3_stb_cnt", 32'(stb_cnt), 32'd3);
    check("t3_err_cnt", 32'(err_cnt), 32'd1);

    // 4: illegal pattern on digit 0 spoils the frame
    frame(7'h7E, 7'h24, BLK, BLK);
    idle(4);
    check("t4_stb_cnt", 32'(stb_cnt), 32'd3);
    check("t4_err_cnt", 32'(err_cnt), 32'd2);
    check("t4_num_out", 32'(num_out), 32'h21);
    check("t4_display_on", 32'(display_on), 32'd1);

    // 5: timeout, then resume with "F0"
    idle(TIMEOUT + 10);
    check("t5_display_off", 32'(display_on), 32'd0);
    check("t5_num_invalid", 32'(num_valid), 32'd0);
    exp_q.push_back(8'hF0);
    frame(7'h40, 7'h0E, BLK, BLK);
    idle(4);
    check("t5_display_on", 32'(display_on), 32'd1);
    check("t5_num_out", 32'(num_out), 32'hF0);
    check("t5_num_valid", 32'(num_valid), 32'd1);
    check("t5_stb_cnt", 32'(stb_cnt), 32'd4);

    // 6: reset after three digits discards the partial frame
    drive(4'b1110, 7'h40, 8);
    drive(4'b1101, 7'h06, 8);
    drive(4'b1011, BLK, 8);
    an     = 4'b1111;
    seg_in = BLK;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rst_num_out", 32'(num_out), 32'h0);
    check("t6_rst_num_valid", 32'(num_valid), 32'd0);
    check("t6_rst_display_on", 32'(display_on), 32'd0);
    check("t6_rst_frame_stb", 32'(frame_stb), 32'd0);
    drive(4'b0111, BLK, 8);
    idle(4);
    check("t6_partial_no_frame", 32'(stb_cnt), 32'd4);
    exp_q.push_back(8'h75);
    drive(4'b1110, 7'h12, 8);
    drive(4'b1101, 7'h78, 8);
    drive(4'b1011, BLK, 8);
    idle(4);
    check("t6_stb_cnt", 32'(stb_cnt), 32'd5);
    check("t6_num_out", 32'(num_out), 32'h75);
    check("t6_err_cnt", 32'(err_cnt), 32'd2);

    check("frames_outstanding", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
